eb_downsize: RTL



---
 rtl/eb_downsize.sv | 70 +++++++
 1 files changed

// File: rtl/eb_downsize.sv
// Wide-to-narrow stream converter: each accepted DWIDTH word is replayed as
// DWIDTH/OWIDTH beats, least-significant slice first, with t_last carried to the final beat.
module eb_downsize #(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] t_data,
  input  logic              t_valid,
  input  logic              t_last,
  output logic              t_ready,
  output logic [OWIDTH-1:0] i_data,
  output logic              i_valid,
  output logic              i_last,
  input  logic              i_ready
);

  localparam int RATIO = DWIDTH / OWIDTH;
  localparam int CW    = (RATIO >= 2) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  generate
    if (RATIO < 2 || (DWIDTH % OWIDTH) != 0) begin : g_bad_ratio
      $error("eb_downsize: DWIDTH must be a multiple of OWIDTH with ratio >= 2");
    end
  endgenerate

  logic [DWIDTH-1:0] r_d;
  logic              r_full;
  logic [CW-1:0]     r_cnt;
  logic              r_lst;

  logic w_at_last;
  logic w_load;
  logic w_xfer;

  assign w_at_last = (r_cnt == LAST_IDX);
  // Back-pressure passes straight through: a new word fits only as the last beat leaves.
  assign t_ready   = !r_full | (i_ready & w_at_last);
  assign w_load    = t_valid & t_ready;
  assign w_xfer    = r_full & i_ready;

  assign i_valid = r_full;
  assign i_data  = r_d[OWIDTH-1:0];
  assign i_last  = r_full & r_lst & w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d    <= '0;
      r_full <= 1'b0;
      r_cnt  <= '0;
      r_lst  <= 1'b0;
    end else if (w_load) begin
      r_d    <= t_data;
      r_lst  <= t_last;
      r_cnt  <= '0;
      r_full <= 1'b1;
    end else if (w_xfer) begin
      if (w_at_last) begin
        r_full <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_d   <= r_d >> OWIDTH;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
